// File: rtl/cached_fetcher_pkg.sv
// Shared enums for the core scheduler and the instruction fetch stage.
package cached_fetcher_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } corestate_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcherstate_t;

endpackage

// File: rtl/cached_fetcher_icache_line_array.sv
// Direct-mapped valid/tag/data storage: combinational read, one write port, sync clear-all.
module icache_line_array #(
    parameter int unsigned Lines    = 4,
    parameter int unsigned TagBits  = 6,
    parameter int unsigned DataBits = 16
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [$clog2(Lines)-1:0] rd_index,
    input  logic [TagBits-1:0]       rd_tag,
    output logic                     rd_hit,
    output logic [DataBits-1:0]      rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(Lines)-1:0] wr_index,
    input  logic [TagBits-1:0]       wr_tag,
    input  logic [DataBits-1:0]      wr_data
);

    logic [Lines-1:0]    valid_q, valid_d;
    logic [TagBits-1:0]  tag_q  [Lines];
    logic [TagBits-1:0]  tag_d  [Lines];
    logic [DataBits-1:0] data_q [Lines];
    logic [DataBits-1:0] data_d [Lines];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
        // Clear wins over a same-edge write so an invalidated fill never survives.
        if (clear) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

    assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data = data_q[rd_index];

endmodule

// File: rtl/cached_fetcher.sv
// Instruction fetch stage with a direct-mapped one-word-per-line cache in front of program memory.
module cached_fetcher
    import cached_fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  corestate_t                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output fetcherstate_t                    fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam int unsigned IdxBits = $clog2(CACHE_LINES);
    localparam int unsigned TagBits = PROGRAM_MEM_ADDR_BITS - IdxBits;

    fetcherstate_t                    state_q, state_d;
    logic                             req_valid_q, req_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic                             poison_q, poison_d;

    logic                             rd_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] rd_data;
    logic                             wr_en;

    icache_line_array #(
        .Lines    (CACHE_LINES),
        .TagBits  (TagBits),
        .DataBits (PROGRAM_MEM_DATA_BITS)
    ) u_lines (
        .clk      (clk),
        .clear    (reset | invalidate),
        .rd_index (current_pc[IdxBits-1:0]),
        .rd_tag   (current_pc[PROGRAM_MEM_ADDR_BITS-1:IdxBits]),
        .rd_hit   (rd_hit),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (req_addr_q[IdxBits-1:0]),
        .wr_tag   (req_addr_q[PROGRAM_MEM_ADDR_BITS-1:IdxBits]),
        .wr_data  (mem_read_data)
    );

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        instr_d     = instr_q;
        poison_d    = poison_q;
        wr_en       = 1'b0;
        unique case (state_q)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    // A lookup racing an invalidate must not trust the line it just read.
                    if (rd_hit && !invalidate) begin
                        instr_d = rd_data;
                        state_d = FETCHER_FETCHED;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = current_pc;
                        state_d     = FETCHER_FETCHING;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (invalidate) begin
                    poison_d = 1'b1;
                end
                if (mem_read_ready) begin
                    instr_d     = mem_read_data;
                    req_valid_d = 1'b0;
                    wr_en       = !(poison_q || invalidate);
                    poison_d    = 1'b0;
                    state_d     = FETCHER_FETCHED;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: begin
                state_d = FETCHER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCHER_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            instr_q     <= '0;
            poison_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            poison_q    <= poison_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = req_valid_q;
    assign mem_read_address = req_addr_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_cached_fetcher.sv
// Scoreboarded directed bench for cached_fetcher: stimulus queues expectations, a monitor checks them.
module tb_cached_fetcher;
    import cached_fetcher_pkg::*;

    logic          clk;
    logic          reset;
    corestate_t    core_state;
    logic [7:0]    current_pc;
    logic          invalidate;
    logic          mem_read_valid;
    logic [7:0]    mem_read_address;
    logic          mem_read_ready;
    logic [15:0]   mem_read_data;
    fetcherstate_t fetcher_state;
    logic [15:0]   instruction;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_instr_q [$];
    logic [7:0]  exp_addr_q  [$];

    cached_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .CACHE_LINES           (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .invalidate       (invalidate),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each entry into FETCHED and each new memory request is matched against the queues.
    fetcherstate_t prev_state;
    logic          prev_valid;
    always @(negedge clk) begin
        if (!reset) begin
            if (fetcher_state == FETCHER_FETCHED && prev_state != FETCHER_FETCHED) begin
                if (exp_instr_q.size() == 0) begin
                    check("unexpected_fetched", 32'(instruction), 32'hFFFF_FFFF);
                end else begin
                    check("sb_instruction", 32'(instruction), 32'(exp_instr_q.pop_front()));
                end
            end
            if (mem_read_valid && !prev_valid) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_request", 32'(mem_read_address), 32'hFFFF_FFFF);
                end else begin
                    check("sb_req_addr", 32'(mem_read_address), 32'(exp_addr_q.pop_front()));
                end
            end
        end
        prev_state = fetcher_state;
        prev_valid = mem_read_valid;
    end

    // inval_mode: 0 none, 1 pulse during FETCHING, 2 pulse together with ready.
    task automatic do_fetch(input logic [7:0] pc, input logic miss, input logic [15:0] data,
                            input int delay, input int inval_mode);
        if (miss) exp_addr_q.push_back(pc);
        else exp_instr_q.push_back(data);
        core_state = CORE_FETCH;
        current_pc = pc;
        tick();
        core_state = CORE_WAIT;
        check("req_issued", 32'(mem_read_valid), 32'(miss));
        if (miss) begin
            for (int i = 0; i < delay - 1; i++) begin
                invalidate = (inval_mode == 1 && i == 0);
                tick();
                invalidate = 1'b0;
                check("req_held_valid", 32'(mem_read_valid), 32'd1);
                check("req_held_addr", 32'(mem_read_address), 32'(pc));
            end
            exp_instr_q.push_back(data);
            mem_read_ready = 1'b1;
            mem_read_data  = data;
            invalidate     = (inval_mode == 2);
            tick();
            mem_read_ready = 1'b0;
            mem_read_data  = 16'h0000;
            invalidate     = 1'b0;
            check("fill_req_dropped", 32'(mem_read_valid), 32'd0);
        end
        check("state_fetched", 32'(fetcher_state), 32'(FETCHER_FETCHED));
        core_state = CORE_DECODE;
        tick();
        core_state = CORE_IDLE;
        check("state_idle_after_decode", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("instr_stable", 32'(instruction), 32'(data));
    endtask

    initial begin
        reset          = 1'b1;
        core_state     = CORE_IDLE;
        current_pc     = 8'h00;
        invalidate     = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        tick();
        // Stale ready during reset/idle must be harmless.
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("rst_valid", 32'(mem_read_valid), 32'd0);
        check("rst_addr", 32'(mem_read_address), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);

        do_fetch(8'h05, 1'b1, 16'h9A07, 3, 0);  // cold miss
        do_fetch(8'h05, 1'b0, 16'h9A07, 0, 0);  // hit
        do_fetch(8'h09, 1'b1, 16'h3123, 1, 0);  // conflict on index 1
        do_fetch(8'h05, 1'b1, 16'h9A07, 2, 0);  // evicted
        do_fetch(8'h06, 1'b1, 16'h1111, 1, 0);
        do_fetch(8'h06, 1'b0, 16'h1111, 0, 0);
        do_fetch(8'h10, 1'b1, 16'hF000, 3, 1);  // invalidate mid-fill
        do_fetch(8'h10, 1'b1, 16'hF000, 1, 0);  // not installed
        do_fetch(8'h06, 1'b1, 16'h1111, 1, 0);  // invalidate cleared index 2 too
        do_fetch(8'h10, 1'b0, 16'hF000, 0, 0);
        do_fetch(8'h07, 1'b1, 16'h7777, 2, 2);  // invalidate with ready
        do_fetch(8'h07, 1'b1, 16'h7777, 1, 0);
        do_fetch(8'h10, 1'b1, 16'hF000, 1, 0);  // lost to the second invalidate

        // Reset while FETCHING abandons the request.
        exp_addr_q.push_back(8'h22);
        core_state = CORE_FETCH;
        current_pc = 8'h22;
        tick();
        core_state = CORE_WAIT;
        tick();
        check("mid_fetch_valid", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_valid", 32'(mem_read_valid), 32'd0);
        check("rst2_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("rst2_instr", 32'(instruction), 32'd0);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        check("late_ready_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("late_ready_instr", 32'(instruction), 32'd0);
        do_fetch(8'h10, 1'b1, 16'hF000, 2, 0);  // cached before reset, must miss

        tick();
        check("sb_instr_drained", 32'(exp_instr_q.size()), 32'd0);
        check("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
